// File: rtl/button_event_queue_if.sv
// Processor-facing data-memory port of the button event queue.
// The master (processor side) drives the address and write strobe; the slave
// (the peripheral) returns read data, the address decode and status flags.
interface button_event_queue_if;
  logic [31:0] mem_addr;
  logic        mem_wren;
  logic [31:0] rd_data;
  logic        hit;
  logic        event_pending;
  logic        overflow;

  modport master (
    output mem_addr,
    output mem_wren,
    input  rd_data,
    input  hit,
    input  event_pending,
    input  overflow
  );

  modport slave (
    input  mem_addr,
    input  mem_wren,
    output rd_data,
    output hit,
    output event_pending,
    output overflow
  );
endinterface

// File: rtl/button_event_queue.sv
// Button event queue: synchronises and debounces BTNU/BTND, turns each debounced
// press into a 2-bit code (1 = up, 2 = down, 3 = both) and queues it in a small
// FIFO that the processor drains one entry per load from IO_ADDR. A store to
// IO_ADDR flushes the queue and clears the sticky overflow flag.
module button_event_queue #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter logic [31:0] IO_ADDR         = 32'd4096
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 btn_up,
  input  logic                 btn_down,
  button_event_queue_if.slave  bus
);

  localparam int unsigned CntW  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned PtrW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntFW = PtrW + 1;
  localparam logic [CntW-1:0]  CntMax   = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CntFW-1:0] FullCnt  = CntFW'(FIFO_DEPTH);

  // Bit 0 is the up button, bit 1 the down button, so a press vector is the event code.
  logic [1:0]           sync1_q, sync2_q;
  logic [1:0]           stable_q, stable_d;
  logic [1:0][CntW-1:0] cnt_q, cnt_d;
  logic [1:0]           evt_q, evt_d;

  logic [FIFO_DEPTH-1:0][1:0] mem_q, mem_d;
  logic [PtrW-1:0]            wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]            rd_ptr_q, rd_ptr_d;
  logic [CntFW-1:0]           count_q, count_d;
  logic                       overflow_q, overflow_d;
  logic                       match_q;

  logic read_en, flush, pop, push_req, push_ok, full, not_empty;

  // Two-flop synchroniser per button.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= 2'b00;
      sync2_q <= 2'b00;
    end else begin
      sync1_q <= {btn_down, btn_up};
      sync2_q <= sync1_q;
    end
  end

  // Debounce: count consecutive cycles the synced level differs from the stable
  // level; flip after DEBOUNCE_CYCLES of them and flag a press on a 0->1 flip.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    evt_d    = 2'b00;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CntMax) begin
        stable_d[i] = ~stable_q[i];
        cnt_d[i]    = '0;
        evt_d[i]    = ~stable_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CntW'(1);
      end
    end
  end

  // Debounce state and the one-cycle press register that feeds the FIFO push.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stable_q <= 2'b00;
      cnt_q    <= '0;
      evt_q    <= 2'b00;
    end else begin
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      evt_q    <= evt_d;
    end
  end

  assign bus.hit = (bus.mem_addr == IO_ADDR);
  assign read_en   = bus.hit && !bus.mem_wren;
  assign flush     = bus.hit && bus.mem_wren;
  assign not_empty = (count_q != '0);
  assign full      = (count_q == FullCnt);
  // Only the first cycle of a held load pops.
  assign pop       = read_en && !match_q && not_empty;
  assign push_req  = (evt_q != 2'b00);
  assign push_ok   = push_req && (!full || pop) && !flush;

  // FIFO next state; a flush overrides any push or pop on the same edge.
  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = evt_q;
        wr_ptr_d        = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      if (push_ok && !pop) begin
        count_d = count_q + CntFW'(1);
      end else if (pop && !push_ok) begin
        count_d = count_q - CntFW'(1);
      end
      if (push_req && !push_ok) begin
        overflow_d = 1'b1;
      end
    end
  end

  // FIFO storage, pointers, occupancy, sticky overflow and the load-edge tracker.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      match_q    <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      match_q    <= read_en;
    end
  end

  // Read data is the registered head, exposed only while a load hits a non-empty queue.
  always_comb begin
    bus.rd_data = 32'b0;
    if (read_en && not_empty) begin
      bus.rd_data = {30'b0, mem_q[rd_ptr_q]};
    end
  end

  assign bus.event_pending = not_empty;
  assign bus.overflow      = overflow_q;

endmodule

// File: tb/tb_button_event_queue.sv
// Bench for button_event_queue with DEBOUNCE_CYCLES=4, FIFO_DEPTH=4.
// Directed stimulus pushes hand-computed event codes into exp_q; a monitor pops
// and compares on the first cycle of every load from IO_ADDR.
module tb_button_event_queue;

  localparam logic [31:0] Addr = 32'd4096;

  logic clock = 1'b0;
  logic reset;
  logic btn_up;
  logic btn_down;

  button_event_queue_if bus ();

  button_event_queue #(
    .DEBOUNCE_CYCLES(4),
    .FIFO_DEPTH     (4),
    .IO_ADDR        (Addr)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .btn_up  (btn_up),
    .btn_down(btn_down),
    .bus     (bus.slave)
  );

  always #5 clock = ~clock;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic press(input logic up, input logic dn);
    btn_up   = up;
    btn_down = dn;
    tick(10);
    btn_up   = 1'b0;
    btn_down = 1'b0;
    tick(10);
  endtask

  task automatic load(input int hold);
    bus.mem_addr = Addr;
    bus.mem_wren = 1'b0;
    tick(hold);
    bus.mem_addr = 32'd0;
    tick(1);
  endtask

  // Monitor: the first cycle of each load must present the expected head (or 0 if empty).
  initial begin
    logic        prev_read;
    logic        rd;
    logic [31:0] exp;
    prev_read = 1'b0;
    forever begin
      @(negedge clock);
      rd = bus.hit && !bus.mem_wren && !reset;
      if (rd && !prev_read) begin
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'd0;
        check("load_data", bus.rd_data, exp);
      end
      prev_read = rd;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b1;
    btn_up       = 1'b0;
    btn_down     = 1'b0;
    bus.mem_addr = 32'd0;
    bus.mem_wren = 1'b0;
    tick(2);
    check("reset_pending", 32'(bus.event_pending), 0);
    check("reset_overflow", 32'(bus.overflow), 0);
    check("reset_rd_data", bus.rd_data, 0);
    reset = 1'b0;
    tick(2);

    // Address decode.
    bus.mem_addr = 32'd4097;
    #1 check("hit_4097", 32'(bus.hit), 0);
    bus.mem_addr = Addr;
    bus.mem_wren = 1'b1;
    #1 check("hit_4096", 32'(bus.hit), 1);
    bus.mem_addr = 32'd0;
    bus.mem_wren = 1'b0;
    tick(1);

    // 1: press-to-visible latency is DEBOUNCE_CYCLES+3 = 7 edges.
    btn_up = 1'b1;
    tick(6);
    check("lat_pending_6", 32'(bus.event_pending), 0);
    tick(1);
    check("lat_pending_7", 32'(bus.event_pending), 1);
    exp_q.push_back(32'd1);
    tick(13);
    btn_up = 1'b0;
    tick(10);
    load(1);
    load(1);
    check("t1_pending", 32'(bus.event_pending), 0);

    // 2: a 3-cycle glitch never reaches the stable level.
    btn_down = 1'b1;
    tick(3);
    btn_down = 1'b0;
    tick(12);
    check("glitch_pending", 32'(bus.event_pending), 0);
    load(1);

    // 3: up, down, down; each load holds the address 5 cycles and pops once.
    press(1'b1, 1'b0);
    exp_q.push_back(32'd1);
    press(1'b0, 1'b1);
    exp_q.push_back(32'd2);
    press(1'b0, 1'b1);
    exp_q.push_back(32'd2);
    check("t3_pending", 32'(bus.event_pending), 1);
    load(5);
    load(5);
    load(5);
    check("t3_drained", 32'(bus.event_pending), 0);
    load(5);

    // 4: both buttons on the same edge give a single code-3 entry.
    press(1'b1, 1'b1);
    exp_q.push_back(32'd3);
    load(1);
    check("t4_single", 32'(bus.event_pending), 0);
    load(1);

    // 5: six presses without reads keep four entries and set overflow; a store flushes.
    for (int i = 0; i < 6; i++) begin
      press(1'b1, 1'b0);
      if (i < 4) exp_q.push_back(32'd1);
      if (i == 3) check("t5_ovf_at_4", 32'(bus.overflow), 0);
    end
    check("t5_ovf_at_6", 32'(bus.overflow), 1);
    check("t5_pending", 32'(bus.event_pending), 1);
    bus.mem_addr = Addr;
    bus.mem_wren = 1'b1;
    tick(1);
    bus.mem_addr = 32'd0;
    bus.mem_wren = 1'b0;
    exp_q.delete();
    check("flush_pending", 32'(bus.event_pending), 0);
    check("flush_overflow", 32'(bus.overflow), 0);
    load(1);

    // 6: full FIFO, press lands on the same edge as a pop -> accepted, no overflow.
    press(1'b1, 1'b0);
    exp_q.push_back(32'd1);
    press(1'b0, 1'b1);
    exp_q.push_back(32'd2);
    press(1'b1, 1'b0);
    exp_q.push_back(32'd1);
    press(1'b0, 1'b1);
    exp_q.push_back(32'd2);
    btn_up   = 1'b1;
    btn_down = 1'b1;
    tick(6);
    bus.mem_addr = Addr;
    tick(1);
    bus.mem_addr = 32'd0;
    exp_q.push_back(32'd3);
    check("t6_overflow", 32'(bus.overflow), 0);
    tick(6);
    btn_up   = 1'b0;
    btn_down = 1'b0;
    tick(10);
    check("t6_overflow_after", 32'(bus.overflow), 0);
    load(1);
    load(1);
    load(1);
    load(1);
    check("t6_drained", 32'(bus.event_pending), 0);
    load(1);

    // Reset with a queued entry and a press mid-debounce discards everything.
    press(1'b1, 1'b0);
    btn_up = 1'b1;
    tick(4);
    reset        = 1'b1;
    btn_up       = 1'b0;
    exp_q.delete();
    bus.mem_addr = Addr;
    #1;
    check("rst_pending", 32'(bus.event_pending), 0);
    check("rst_overflow", 32'(bus.overflow), 0);
    check("rst_rd_data", bus.rd_data, 0);
    tick(2);
    bus.mem_addr = 32'd0;
    tick(1);
    reset = 1'b0;
    tick(15);
    check("rst_no_event", 32'(bus.event_pending), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
